ysyx_24100005_ifu: RTL and testbench

Instruction fetch unit for the multi-cycle NPC core: owns the PC, issues one 32-bit fetch at a time to instruction memory over a valid/ready request plus valid-only response, and hands the fetched word with its PC to decode, which indexes the register file from it. It accepts a PC redirect from execute (branch/jump/trap) at any time and discards any in-flight fetch made stale by it.

---
 rtl/ysyx_24100005_ifu_pkg.sv | 14 +
 rtl/ysyx_24100005_ifu_if.sv | 36 +++
 rtl/ysyx_24100005_ifu.sv | 111 +++++++++++
 tb/tb_ysyx_24100005_ifu.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100005_ifu_pkg.sv
// Shared definitions for the NPC instruction fetch unit: FSM states and fetch constants.
package ysyx_24100005_ifu_pkg;

    localparam int unsigned INST_BYTES       = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StHold,
        StFault
    } ifu_state_e;

endpackage

// File: rtl/ysyx_24100005_ifu_if.sv
// Fetch-unit bundle: instruction-memory request/response, decode handoff, redirect and fault.
interface ysyx_24100005_ifu_if #(
    parameter int unsigned XLEN = 32
) ();

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            imem_rsp_err;
    logic            inst_valid;
    logic [31:0]     inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready, redirect_valid, redirect_pc,
        output fetch_fault
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready, redirect_valid, redirect_pc,
        input  fetch_fault
    );

endinterface

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: owns the PC, keeps one fetch in flight and hands words to decode.
// Redirects take priority in every state; a stale in-flight response is absorbed via kill.
module ysyx_24100005_ifu
    import ysyx_24100005_ifu_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input logic                 clk,
    input logic                 rst,
    ysyx_24100005_ifu_if.master bus
);

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_buf_q, inst_buf_d;
    logic            kill_q, kill_d;

    logic            req_valid;
    logic            fire;
    logic            pending_after;
    logic            misaligned;

    // A killed response still owed by memory blocks new requests until it lands.
    assign req_valid  = (state_q == StReq) && !kill_q;
    assign fire       = req_valid && bus.imem_req_ready;
    assign misaligned = bus.redirect_pc[1:0] != 2'b00;
    assign pending_after = fire || (((state_q == StWait) || kill_q) && !bus.imem_rsp_valid);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_buf_d = inst_buf_q;
        kill_d     = kill_q;

        if (bus.redirect_valid) begin
            pc_d   = bus.redirect_pc;
            kill_d = pending_after;
            if (misaligned) begin
                state_d = StFault;
            end else if (pending_after && ((state_q == StWait) || fire)) begin
                state_d = StWait;
            end else begin
                state_d = StReq;
            end
        end else begin
            unique case (state_q)
                StReq: begin
                    if (kill_q && bus.imem_rsp_valid) kill_d = 1'b0;
                    if (fire) state_d = StWait;
                end
                StWait: begin
                    if (bus.imem_rsp_valid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = StReq;
                        end else if (bus.imem_rsp_err) begin
                            state_d = StFault;
                        end else begin
                            inst_buf_d = bus.imem_rsp_data;
                            state_d    = StHold;
                        end
                    end
                end
                StHold: begin
                    if (bus.inst_ready) begin
                        pc_d    = pc_q + XLEN'(INST_BYTES);
                        state_d = StReq;
                    end
                end
                StFault: begin
                    if (bus.imem_rsp_valid) kill_d = 1'b0;
                end
                default: state_d = StReq;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StReq;
            pc_q       <= RESET_PC;
            inst_buf_q <= 32'h0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_buf_q <= inst_buf_d;
            kill_q     <= kill_d;
        end
    end

    // Outputs decode registered state only; reset forces them low.
    always_comb begin
        bus.imem_req_valid = 1'b0;
        bus.imem_req_addr  = '0;
        bus.inst_valid     = 1'b0;
        bus.inst_data      = 32'h0;
        bus.inst_pc        = '0;
        bus.fetch_fault    = 1'b0;
        if (!rst) begin
            bus.imem_req_valid = req_valid;
            bus.imem_req_addr  = pc_q;
            bus.inst_valid     = state_q == StHold;
            bus.inst_data      = inst_buf_q;
            bus.inst_pc        = pc_q;
            bus.fetch_fault    = state_q == StFault;
        end
    end

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Self-checking bench for ysyx_24100005_ifu: directed scenarios plus a randomized run
// against a transaction-level PC model and a memory model with random ready/latency.
module tb_ysyx_24100005_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    // Memory model state
    int          mem_ready_pct;
    int          lat_min;
    int          lat_max;
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;
    bit          err_all;

    ysyx_24100005_ifu_if bus ();

    ysyx_24100005_ifu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Drive memory inputs for the coming edge from current outputs, then advance one cycle.
    task automatic tick();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_err   = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = memfn(mem_addr);
                bus.imem_rsp_err   = err_all;
                mem_pend           = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        bus.imem_req_ready = ($urandom_range(99) < mem_ready_pct);
        if (bus.imem_req_valid && bus.imem_req_ready && !rst) begin
            checks++;
            if (mem_pend) begin
                errors++;
                $display("FAIL one_outstanding: second request addr=%h accepted, required none", bus.imem_req_addr);
            end
            mem_pend = 1'b1;
            mem_addr = bus.imem_req_addr;
            mem_cnt  = $urandom_range(lat_max, lat_min) - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_inst(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (bus.inst_valid) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
        ok = bus.inst_valid;
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        tick();
        tick();
        mem_pend = 1'b0;
        rst      = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid, bus.inst_data, bus.inst_pc,
             bus.fetch_fault} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req_v=%b addr=%h inst_v=%b fault=%b, required all 0",
                     bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid, bus.fetch_fault);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RST_PC || bus.inst_valid !== 1'b0
            || bus.fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: req_v=%b addr=%h inst_v=%b fault=%b, required 1 %h 0 0",
                     bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid, bus.fetch_fault, RST_PC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        mem_ready_pct  = 100;
        lat_min        = 1;
        lat_max        = 1;
        bus.inst_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            exp_pc = RST_PC + 32'(4 * (k / 3));
            checks++;
            if (bus.imem_req_valid !== (k % 3 == 0) || bus.inst_valid !== (k % 3 == 2)) begin
                errors++;
                $display("FAIL seq_timing[%0d]: req_v=%b inst_v=%b, required %b %b", k,
                         bus.imem_req_valid, bus.inst_valid, k % 3 == 0, k % 3 == 2);
            end
            if (k % 3 == 0) begin
                checks++;
                if (bus.imem_req_addr !== exp_pc) begin
                    errors++;
                    $display("FAIL seq_addr[%0d]: addr=%h, required %h", k, bus.imem_req_addr, exp_pc);
                end
            end
            if (k % 3 == 2) begin
                checks++;
                if (bus.inst_pc !== exp_pc || bus.inst_data !== memfn(exp_pc)) begin
                    errors++;
                    $display("FAIL seq_inst[%0d]: pc=%h data=%h, required %h %h", k, bus.inst_pc,
                             bus.inst_data, exp_pc, memfn(exp_pc));
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        bit          ok;
        logic [31:0] pc0;
        bus.inst_ready = 1'b0;
        run_until_inst(10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_arrive: inst_valid=0 after timeout, required 1");
        end
        pc0 = RST_PC + 32'd12;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== pc0 || bus.inst_data !== memfn(pc0)
                || bus.imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: inst_v=%b pc=%h data=%h req_v=%b, required 1 %h %h 0",
                         k, bus.inst_valid, bus.inst_pc, bus.inst_data, bus.imem_req_valid, pc0,
                         memfn(pc0));
            end
            tick();
        end
        bus.inst_ready = 1'b1;
        tick();
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b1
            || bus.imem_req_addr !== pc0 + 32'd4) begin
            errors++;
            $display("FAIL stall_release: inst_v=%b req_v=%b addr=%h, required 0 1 %h",
                     bus.inst_valid, bus.imem_req_valid, bus.imem_req_addr, pc0 + 32'd4);
        end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        bit saw_inst;
        do_reset();
        lat_min = 5;
        lat_max = 5;
        tick();
        checks++;
        if (bus.imem_req_valid !== 1'b0 || !mem_pend) begin
            errors++;
            $display("FAIL rdw_in_wait: req_v=%b accepted=%b, required 0 1", bus.imem_req_valid, mem_pend);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0100;
        tick();
        bus.redirect_valid = 1'b0;
        saw_inst = 1'b0;
        for (int i = 0; i < 20 && !bus.imem_req_valid; i++) begin
            saw_inst |= bus.inst_valid;
            tick();
        end
        checks++;
        if (saw_inst || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0100) begin
            errors++;
            $display("FAIL rdw_reissue: stale_inst=%b req_v=%b addr=%h, required 0 1 80000100",
                     saw_inst, bus.imem_req_valid, bus.imem_req_addr);
        end
        lat_min = 1;
        lat_max = 1;
        run_until_inst(10, ok);
        checks++;
        if (!ok || bus.inst_pc !== 32'h8000_0100 || bus.inst_data !== memfn(32'h8000_0100)) begin
            errors++;
            $display("FAIL rdw_deliver: valid=%b pc=%h data=%h, required 1 80000100 %h", ok,
                     bus.inst_pc, bus.inst_data, memfn(32'h8000_0100));
        end
    endtask

    task automatic test_redirect_hold();
        bit ok;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0040;
        tick();
        bus.redirect_valid = 1'b0;
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b1
            || bus.imem_req_addr !== 32'h8000_0040) begin
            errors++;
            $display("FAIL rdh_addr: inst_v=%b req_v=%b addr=%h, required 0 1 80000040",
                     bus.inst_valid, bus.imem_req_valid, bus.imem_req_addr);
        end
        run_until_inst(10, ok);
        checks++;
        if (!ok || bus.inst_pc !== 32'h8000_0040) begin
            errors++;
            $display("FAIL rdh_deliver: valid=%b pc=%h, required 1 80000040", ok, bus.inst_pc);
        end
    endtask

    task automatic test_fault();
        bit ok;
        err_all = 1'b1;
        for (int i = 0; i < 10 && !bus.fetch_fault; i++) tick();
        err_all = 1'b0;
        checks++;
        if (bus.fetch_fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_set: fetch_fault=%b, required 1", bus.fetch_fault);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0 || bus.fetch_fault !== 1'b1) begin
                errors++;
                $display("FAIL fault_quiet[%0d]: req_v=%b inst_v=%b fault=%b, required 0 0 1", k,
                         bus.imem_req_valid, bus.inst_valid, bus.fetch_fault);
            end
            tick();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = RST_PC;
        tick();
        bus.redirect_valid = 1'b0;
        checks++;
        if (bus.fetch_fault !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RST_PC) begin
            errors++;
            $display("FAIL fault_clear: fault=%b req_v=%b addr=%h, required 0 1 %h",
                     bus.fetch_fault, bus.imem_req_valid, bus.imem_req_addr, RST_PC);
        end
        bus.inst_ready = 1'b0;
        run_until_inst(10, ok);
        checks++;
        if (!ok || bus.inst_pc !== RST_PC) begin
            errors++;
            $display("FAIL fault_resume: valid=%b pc=%h, required 1 %h", ok, bus.inst_pc, RST_PC);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0002;
        tick();
        bus.redirect_valid = 1'b0;
        checks++;
        if (bus.fetch_fault !== 1'b1 || bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL misalign: fault=%b req_v=%b inst_v=%b, required 1 0 0", bus.fetch_fault,
                     bus.imem_req_valid, bus.inst_valid);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b1;
        run_until_inst(10, ok);
        checks++;
        if (!ok || bus.inst_pc !== 32'hFFFF_FFFC || bus.inst_data !== memfn(32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL wrap_inst: valid=%b pc=%h data=%h, required 1 fffffffc %h", ok,
                     bus.inst_pc, bus.inst_data, memfn(32'hFFFF_FFFC));
        end
        tick();
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr: req_v=%b addr=%h, required 1 00000000", bus.imem_req_valid,
                     bus.imem_req_addr);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        bit bad;
        lat_min = 4;
        lat_max = 4;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.imem_req_valid, bus.inst_valid, bus.fetch_fault, bus.imem_req_addr} !== '0) begin
            errors++;
            $display("FAIL rmw_in_reset: req_v=%b inst_v=%b fault=%b addr=%h, required 0 0 0 0",
                     bus.imem_req_valid, bus.inst_valid, bus.fetch_fault, bus.imem_req_addr);
        end
        rst = 1'b0;
        #1;
        mem_ready_pct = 0;
        bad = 1'b0;
        for (int i = 0; i < 10 && mem_pend; i++) begin
            bad |= (bus.imem_req_valid !== 1'b1) || (bus.imem_req_addr !== RST_PC) || bus.inst_valid;
            tick();
        end
        bad |= mem_pend || (bus.imem_req_valid !== 1'b1) || (bus.imem_req_addr !== RST_PC)
               || bus.inst_valid;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rmw_stale: req_v=%b addr=%h inst_v=%b, required 1 %h 0 throughout",
                     bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid, RST_PC);
        end
        mem_ready_pct = 100;
        lat_min       = 1;
        lat_max       = 1;
        run_until_inst(10, ok);
        checks++;
        if (!ok || bus.inst_pc !== RST_PC || bus.inst_data !== memfn(RST_PC)) begin
            errors++;
            $display("FAIL rmw_deliver: valid=%b pc=%h data=%h, required 1 %h %h", ok, bus.inst_pc,
                     bus.inst_data, RST_PC, memfn(RST_PC));
        end
    endtask

    task automatic test_random();
        logic [31:0] model_pc;
        int          delivered;
        bit          redir;
        do_reset();
        mem_ready_pct = 60;
        lat_min       = 1;
        lat_max       = 4;
        model_pc      = RST_PC;
        delivered     = 0;
        for (int c = 0; c < 3000; c++) begin
            if (bus.inst_valid) begin
                delivered++;
                checks++;
                if (bus.inst_pc !== model_pc || bus.inst_data !== memfn(model_pc)) begin
                    errors++;
                    $display("FAIL rand_inst@%0d: pc=%h data=%h, required %h %h", c, bus.inst_pc,
                             bus.inst_data, model_pc, memfn(model_pc));
                end
            end
            if (bus.imem_req_valid) begin
                checks++;
                if (bus.imem_req_addr !== model_pc) begin
                    errors++;
                    $display("FAIL rand_addr@%0d: addr=%h, required %h", c, bus.imem_req_addr, model_pc);
                end
            end
            if (bus.fetch_fault !== 1'b0) begin
                errors++;
                checks++;
                $display("FAIL rand_fault@%0d: fetch_fault=%b, required 0", c, bus.fetch_fault);
            end
            bus.inst_ready     = 1'($urandom_range(1));
            redir              = $urandom_range(99) < 3;
            bus.redirect_valid = redir;
            bus.redirect_pc    = RST_PC + ($urandom_range(1023) << 2);
            if (redir) model_pc = bus.redirect_pc;
            else if (bus.inst_valid && bus.inst_ready) model_pc = model_pc + 32'd4;
            tick();
        end
        bus.redirect_valid = 1'b0;
        checks++;
        if (delivered < 100) begin
            errors++;
            $display("FAIL rand_progress: delivered=%0d, required at least 100", delivered);
        end
    endtask

    initial begin
        errors             = 0;
        checks             = 0;
        mem_ready_pct      = 100;
        lat_min            = 1;
        lat_max            = 1;
        mem_pend           = 1'b0;
        mem_cnt            = 0;
        mem_addr           = 32'h0;
        err_all            = 1'b0;
        rst                = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.imem_rsp_err   = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_fault();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
